// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline front-end control blocks.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    HALTED = 2'd2
  } ctrl_state_t;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INST   = 32'h0;
  localparam int          PC_STEP    = 4;

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds the IF/ID instruction.
module hazard_detect #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs2,
  output logic                  hazard
);
  import pipe_ctrl_pkg::*;

  // x0 is hard-wired to zero, so a load into it never creates a dependency.
  assign hazard = mem_read & (rd != '0) &
                  ((rd == rs1) | (uses_rs2 & (rd == rs2)));

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Front-end controller: PC register, branch redirect, load-use stall and halt
// sequencing, with a saturating stall-cycle counter.
module fetch_hazard_ctrl #(
  parameter int INS_ADDRESS = 9,
  parameter int REG_ADDR_W  = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int LOAD_LAT    = 1,
  parameter int CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_br_taken,
  input  logic [INS_ADDRESS-1:0] ex_br_target,
  input  logic                   idex_mem_read,
  input  logic [REG_ADDR_W-1:0]  idex_rd,
  input  logic [REG_ADDR_W-1:0]  ifid_rs1,
  input  logic [REG_ADDR_W-1:0]  ifid_rs2,
  input  logic                   ifid_uses_rs2,
  input  logic                   halt_req,
  output logic [INS_ADDRESS-1:0] pc,
  output logic                   ifid_en,
  output logic                   ifid_flush,
  output logic                   idex_bubble,
  output logic                   halted,
  output logic [CNT_W-1:0]       stall_count
);
  import pipe_ctrl_pkg::*;

  localparam int             LAT_W  = 4;
  localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LOAD_LAT - 1);

  ctrl_state_t            state, state_n;
  logic [INS_ADDRESS-1:0] pc_n, pc_seq;
  logic [LAT_W-1:0]       cnt, cnt_n;
  logic [CNT_W-1:0]       stall_count_n;
  logic                   hazard;
  logic                   stall_cycle;

  hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .mem_read(idex_mem_read),
    .rd      (idex_rd),
    .rs1     (ifid_rs1),
    .rs2     (ifid_rs2),
    .uses_rs2(ifid_uses_rs2),
    .hazard  (hazard)
  );

  // Natural overflow of the adder gives the 508 -> 0 wrap.
  assign pc_seq = pc + INS_ADDRESS'(PC_STEP);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= RUN;
      pc          <= '0;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      cnt         <= cnt_n;
      stall_count <= stall_count_n;
    end
  end

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    cnt_n       = cnt;
    stall_cycle = 1'b0;
    case (state)
      HALTED: ;
      default: begin
        if (ex_br_taken) begin
          state_n = RUN;
          pc_n    = ex_br_target;
          cnt_n   = '0;
        end else if (state == STALL) begin
          // Hazard is not re-evaluated here; the load is already past ID/EX.
          stall_cycle = 1'b1;
          cnt_n       = cnt - 1'b1;
          if (cnt == LAT_W'(1)) state_n = RUN;
        end else if (hazard) begin
          stall_cycle = 1'b1;
          if (LOAD_LAT > 1) begin
            state_n = STALL;
            cnt_n   = LAT_M1;
          end
        end else if (halt_req) begin
          state_n = HALTED;
        end else begin
          pc_n = pc_seq;
        end
      end
    endcase
    stall_count_n = (stall_cycle && (stall_count != '1)) ? stall_count + 1'b1
                                                          : stall_count;
  end

  always_comb begin
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == HALTED) begin
      ifid_flush = 1'b1;
    end else if (ex_br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((state == STALL) || hazard) begin
      idex_bubble = 1'b1;
    end else if (halt_req) begin
      // Fetch freezes from the halt cycle on; IF/ID is fed a NOP.
      ifid_flush = 1'b1;
    end else begin
      ifid_en = 1'b1;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench: table-driven cycles on a LOAD_LAT=1 instance plus hand sequences
// on a LOAD_LAT=3 instance with a 2-bit stall counter.
module tb_fetch_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: LOAD_LAT=1, full-width counter
  logic       a_rst, a_br, a_mr, a_u2, a_halt;
  logic [8:0] a_tgt;
  logic [4:0] a_rd, a_rs1, a_rs2;
  logic [8:0] a_pc;
  logic       a_en, a_fl, a_bub, a_halted;
  logic [15:0] a_sc;

  fetch_hazard_ctrl #(.INS_ADDRESS(9), .REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(a_rst), .ex_br_taken(a_br), .ex_br_target(a_tgt),
    .idex_mem_read(a_mr), .idex_rd(a_rd), .ifid_rs1(a_rs1), .ifid_rs2(a_rs2),
    .ifid_uses_rs2(a_u2), .halt_req(a_halt), .pc(a_pc), .ifid_en(a_en),
    .ifid_flush(a_fl), .idex_bubble(a_bub), .halted(a_halted), .stall_count(a_sc)
  );

  // Instance B: LOAD_LAT=3, 2-bit counter so saturation is reachable
  logic       b_rst, b_br, b_mr, b_u2, b_halt;
  logic [8:0] b_tgt;
  logic [4:0] b_rd, b_rs1, b_rs2;
  logic [8:0] b_pc;
  logic       b_en, b_fl, b_bub, b_halted;
  logic [1:0] b_sc;

  fetch_hazard_ctrl #(.INS_ADDRESS(9), .REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(2)) dut_b (
    .clk(clk), .rst(b_rst), .ex_br_taken(b_br), .ex_br_target(b_tgt),
    .idex_mem_read(b_mr), .idex_rd(b_rd), .ifid_rs1(b_rs1), .ifid_rs2(b_rs2),
    .ifid_uses_rs2(b_u2), .halt_req(b_halt), .pc(b_pc), .ifid_en(b_en),
    .ifid_flush(b_fl), .idex_bubble(b_bub), .halted(b_halted), .stall_count(b_sc)
  );

  typedef struct {
    logic       rst, br;
    logic [8:0] tgt;
    logic       mr;
    logic [4:0] rd, rs1, rs2;
    logic       u2, halt;
    logic [8:0] pc;
    logic       en, fl, bub, hlt;
    logic [15:0] sc;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic b_idle();
    b_br = 0; b_tgt = '0; b_mr = 0; b_rd = '0; b_rs1 = '0; b_rs2 = '0; b_u2 = 0; b_halt = 0;
  endtask

  task automatic b_hazard_rs2();
    b_mr = 1; b_rd = 5'd7; b_rs1 = 5'd2; b_rs2 = 5'd7; b_u2 = 1;
  endtask

  task automatic b_chk(input string nm, input logic [8:0] pc_e, input logic en_e,
                       input logic fl_e, input logic bub_e, input logic [1:0] sc_e);
    #1;
    chk({nm, ".pc"}, 32'(b_pc), 32'(pc_e));
    chk({nm, ".en"}, 32'(b_en), 32'(en_e));
    chk({nm, ".flush"}, 32'(b_fl), 32'(fl_e));
    chk({nm, ".bubble"}, 32'(b_bub), 32'(bub_e));
    chk({nm, ".stall_count"}, 32'(b_sc), 32'(sc_e));
  endtask

  initial begin
    //         rst br tgt   mr rd rs1 rs2 u2 halt | pc   en fl bub hlt sc
    tbl[0]  = '{0, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'd0,   0, 1, 1, 0, 0};
    tbl[1]  = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'd0,   1, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'd4,   1, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'd8,   1, 0, 0, 0, 0};
    tbl[4]  = '{1, 0, 9'd0,   1, 3, 3, 0, 0, 0,    9'd12,  0, 0, 1, 0, 0};
    tbl[5]  = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'd12,  1, 0, 0, 0, 1};
    tbl[6]  = '{1, 0, 9'd0,   1, 0, 0, 0, 0, 0,    9'd16,  1, 0, 0, 0, 1};
    tbl[7]  = '{1, 0, 9'd0,   1, 5, 1, 5, 0, 0,    9'd20,  1, 0, 0, 0, 1};
    tbl[8]  = '{1, 0, 9'd0,   1, 5, 1, 5, 1, 0,    9'd24,  0, 0, 1, 0, 1};
    tbl[9]  = '{1, 1, 9'h40,  1, 3, 3, 0, 0, 0,    9'd24,  0, 1, 1, 0, 2};
    tbl[10] = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'h40,  1, 0, 0, 0, 2};
    tbl[11] = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'h44,  1, 0, 0, 0, 2};
    tbl[12] = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 1,    9'h48,  0, 1, 0, 0, 2};
    tbl[13] = '{1, 1, 9'h80,  0, 0, 0, 0, 0, 0,    9'h48,  0, 1, 0, 1, 2};
    tbl[14] = '{1, 0, 9'd0,   1, 3, 3, 0, 0, 1,    9'h48,  0, 1, 0, 1, 2};
    tbl[15] = '{0, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'h48,  0, 1, 1, 1, 2};
    tbl[16] = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'd0,   1, 0, 0, 0, 0};
    tbl[17] = '{1, 0, 9'd0,   0, 0, 0, 0, 0, 0,    9'd4,   1, 0, 0, 0, 0};

    a_rst = 0; a_br = 0; a_tgt = '0; a_mr = 0; a_rd = '0; a_rs1 = '0; a_rs2 = '0;
    a_u2 = 0; a_halt = 0;
    b_rst = 0; b_idle();
    step();

    for (int i = 0; i < 18; i++) begin
      a_rst = tbl[i].rst; a_br = tbl[i].br; a_tgt = tbl[i].tgt; a_mr = tbl[i].mr;
      a_rd = tbl[i].rd; a_rs1 = tbl[i].rs1; a_rs2 = tbl[i].rs2; a_u2 = tbl[i].u2;
      a_halt = tbl[i].halt;
      #1;
      chk($sformatf("row%0d.pc", i), 32'(a_pc), 32'(tbl[i].pc));
      chk($sformatf("row%0d.en", i), 32'(a_en), 32'(tbl[i].en));
      chk($sformatf("row%0d.flush", i), 32'(a_fl), 32'(tbl[i].fl));
      chk($sformatf("row%0d.bubble", i), 32'(a_bub), 32'(tbl[i].bub));
      chk($sformatf("row%0d.halted", i), 32'(a_halted), 32'(tbl[i].hlt));
      chk($sformatf("row%0d.stall_count", i), 32'(a_sc), 32'(tbl[i].sc));
      step();
    end

    // Free-run to the top of the address space and wrap
    a_rst = 1; a_br = 0; a_mr = 0; a_halt = 0;
    for (int i = 0; i < 200 && a_pc != 9'd508; i++) step();
    #1;
    chk("wrap.reach508", 32'(a_pc), 32'd508);
    chk("wrap.en_at_508", 32'(a_en), 32'd1);
    step();
    #1;
    chk("wrap.pc_after", 32'(a_pc), 32'd0);
    a_halt = 1;
    #1;
    chk("halt.entry_en", 32'(a_en), 32'd0);
    chk("halt.entry_flush", 32'(a_fl), 32'd1);
    step();
    a_halt = 0; a_br = 1; a_tgt = 9'h100;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("halted%0d.halted", i), 32'(a_halted), 32'd1);
      chk($sformatf("halted%0d.pc", i), 32'(a_pc), 32'd0);
      chk($sformatf("halted%0d.flush", i), 32'(a_fl), 32'd1);
      chk($sformatf("halted%0d.en", i), 32'(a_en), 32'd0);
      step();
    end
    a_br = 0;

    // Instance B: three-cycle load-use stall via rs2
    b_rst = 1; b_idle();
    b_chk("b_run0", 9'd0, 1, 0, 0, 2'd0); step();
    b_chk("b_run1", 9'd4, 1, 0, 0, 2'd0); step();
    b_hazard_rs2();
    b_chk("b_st1", 9'd8, 0, 0, 1, 2'd0); step();
    b_idle();
    b_chk("b_st2", 9'd8, 0, 0, 1, 2'd1); step();
    b_chk("b_st3", 9'd8, 0, 0, 1, 2'd2); step();
    b_chk("b_resume", 9'd8, 1, 0, 0, 2'd3); step();
    b_hazard_rs2(); b_u2 = 0;
    b_chk("b_no_rs2", 9'd12, 1, 0, 0, 2'd3); step();

    // Second stall: 2-bit counter must hold at 3
    b_hazard_rs2();
    b_chk("b_sat1", 9'd16, 0, 0, 1, 2'd3); step();
    b_idle();
    b_chk("b_sat2", 9'd16, 0, 0, 1, 2'd3); step();
    b_chk("b_sat3", 9'd16, 0, 0, 1, 2'd3); step();
    b_chk("b_sat_done", 9'd16, 1, 0, 0, 2'd3); step();

    // Reset in the second cycle of a stall
    b_hazard_rs2();
    b_chk("b_rs_st1", 9'd20, 0, 0, 1, 2'd3); step();
    b_idle(); b_rst = 0;
    b_chk("b_rs_hold", 9'd20, 0, 1, 1, 2'd3); step();
    b_rst = 1;
    b_chk("b_rs_after", 9'd0, 1, 0, 0, 2'd0);
    chk("b_rs_after.halted", 32'(b_halted), 32'd0);
    step();
    b_chk("b_rs_next", 9'd4, 1, 0, 0, 2'd0); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
